// File: rtl/stw_bist_sequencer_if.sv
// Broadcast self-test-word bus between the BIST sequencer (master) and the MAC array (slave).
interface stw_bist_sequencer_if #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int WORD_SIZE = 16
);
   logic [WORD_SIZE-1:0] STW_mult_op1;
   logic [WORD_SIZE-1:0] STW_mult_op2;
   logic [WORD_SIZE-1:0] STW_add_op;
   logic [WORD_SIZE-1:0] STW_expected;
   logic                 STW_test_load_en;
   logic                 STW_start;
   logic                 STW_complete_out;
   logic [ROWS*COLS-1:0] STW_result_mat;

   modport master (
      output STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected,
      output STW_test_load_en, STW_start,
      input  STW_complete_out, STW_result_mat
   );

   modport slave (
      input  STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected,
      input  STW_test_load_en, STW_start,
      output STW_complete_out, STW_result_mat
   );
endinterface

// File: rtl/stw_bist_sequencer.sv
// STW BIST controller: steps a programmable vector list through the MAC array,
// waits for the array-wide completion and folds per-PE mismatches into a sticky fault map.
module stw_bist_sequencer #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int WORD_SIZE      = 16,
   parameter int NUM_VECTORS    = 4,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int IDX_W         = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bist_start,
   input  logic                   bist_abort,
   input  logic                   vec_wr_en,
   input  logic [IDX_W-1:0]       vec_wr_addr,
   input  logic [3*WORD_SIZE-1:0] vec_wr_data,
   stw_bist_sequencer_if.master   stw,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err,
   output logic [IDX_W-1:0]       vec_idx,
   output logic [ROWS*COLS-1:0]   fault_map,
   output logic                   any_fault
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_DONE, S_ERROR
   } state_t;

   state_t                 state, state_next;
   logic [3*WORD_SIZE-1:0] slots [NUM_VECTORS];
   logic [WORD_SIZE-1:0]   op1, op2, add_op;
   logic [CNT_W-1:0]       wait_cnt;
   logic [IDX_W-1:0]       idx_next;
   logic                   launch, capture, cnt_clr, cnt_inc, last_vec;

   assign last_vec = (vec_idx == IDX_W'(NUM_VECTORS - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next           = state;
      idx_next             = vec_idx;
      launch               = 1'b0;
      capture              = 1'b0;
      cnt_clr              = 1'b0;
      cnt_inc              = 1'b0;
      busy                 = 1'b0;
      done                 = 1'b0;
      timeout_err          = 1'b0;
      stw.STW_test_load_en = 1'b0;
      stw.STW_start        = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            done        = (state == S_DONE);
            timeout_err = (state == S_ERROR);
            if (bist_start) begin
               launch     = 1'b1;
               idx_next   = '0;
               state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            busy                 = 1'b1;
            stw.STW_test_load_en = 1'b1;
            state_next           = S_START;
         end
         S_START: begin
            busy          = 1'b1;
            stw.STW_start = 1'b1;
            cnt_clr       = 1'b1;
            state_next    = S_WAIT;
         end
         S_WAIT: begin
            busy    = 1'b1;
            cnt_inc = 1'b1;
            // wait_cnt==0 marks the first WAIT cycle, where complete may still be stale
            if (wait_cnt != '0 && stw.STW_complete_out)
               state_next = S_CAPTURE;
            else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
               state_next = S_ERROR;
         end
         S_CAPTURE: begin
            busy    = 1'b1;
            capture = 1'b1;
            if (last_vec) begin
               state_next = S_DONE;
            end else begin
               idx_next   = vec_idx + IDX_W'(1);
               state_next = S_LOAD;
            end
         end
         default: state_next = S_IDLE;
      endcase
      // abort wins over everything, including a capture in the same cycle
      if (busy && bist_abort) begin
         state_next = S_IDLE;
         capture    = 1'b0;
         idx_next   = vec_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_VECTORS; i++) slots[i] <= '0;
         op1       <= '0;
         op2       <= '0;
         add_op    <= '0;
         wait_cnt  <= '0;
         vec_idx   <= '0;
         fault_map <= '0;
      end else begin
         if (vec_wr_en && !busy && (32'(vec_wr_addr) < NUM_VECTORS))
            slots[vec_wr_addr] <= vec_wr_data;
         vec_idx <= idx_next;
         if (state_next == S_LOAD)
            {add_op, op2, op1} <= slots[idx_next];
         else if (state_next == S_IDLE)
            {add_op, op2, op1} <= '0;
         if (cnt_clr)      wait_cnt <= '0;
         else if (cnt_inc) wait_cnt <= wait_cnt + CNT_W'(1);
         if (launch)       fault_map <= '0;
         else if (capture) fault_map <= fault_map | stw.STW_result_mat;
      end
   end

   assign stw.STW_mult_op1 = op1;
   assign stw.STW_mult_op2 = op2;
   assign stw.STW_add_op   = add_op;
   assign stw.STW_expected = op1 * op2 + add_op;
   assign any_fault        = |fault_map;

endmodule

// File: tb/tb_stw_bist_sequencer.sv
// Directed and randomized bench for stw_bist_sequencer: an array responder plus a
// cycle-timeline reference model derived from the per-vector latency rules.
module tb_stw_bist_sequencer;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int W    = 16;
   localparam int NV   = 2;
   localparam int TO   = 8;

   logic        clk = 1'b0;
   logic        rst, bist_start, bist_abort, vec_wr_en;
   logic [0:0]  vec_wr_addr;
   logic [47:0] vec_wr_data;
   logic        busy, done, timeout_err, any_fault;
   logic [0:0]  vec_idx;
   logic [15:0] fault_map;

   int vectors     = 0;
   int miscompares = 0;

   logic [47:0] slot_m [NV];
   int          dly    [NV];   // cycles after STW_start until complete rises; 0 = never
   logic [15:0] res    [NV];

   stw_bist_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W)) stw ();

   stw_bist_sequencer #(
      .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .NUM_VECTORS(NV), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .bist_start(bist_start), .bist_abort(bist_abort),
      .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
      .stw(stw), .busy(busy), .done(done), .timeout_err(timeout_err),
      .vec_idx(vec_idx), .fault_map(fault_map), .any_fault(any_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] stw_exp(input logic [47:0] s);
      longint p;
      p = longint'(s[15:0]) * longint'(s[31:16]) + longint'(s[47:32]);
      return 16'(p % 65536);
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_tmo"}, timeout_err, 0);
      check({tag, "_idx"}, vec_idx, 0);
      check({tag, "_map"}, fault_map, 0);
      check({tag, "_any"}, any_fault, 0);
      check({tag, "_ops"}, {stw.STW_mult_op1, stw.STW_mult_op2, stw.STW_add_op, stw.STW_expected}, 0);
      check({tag, "_strb"}, {stw.STW_test_load_en, stw.STW_start}, 0);
   endtask

   task automatic write_slot(input int a, input logic [47:0] d);
      vec_wr_en = 1'b1; vec_wr_addr = 1'(a); vec_wr_data = d;
      @(negedge clk);
      vec_wr_en = 1'b0;
      slot_m[a] = d;
   endtask

   // Cycle 0 is the negedge on entry (start sampled at its end); exp_* derive from latency rules.
   task automatic run_bist(input string tag, input bit stale, input int abort_cyc,
                           input int intr_cyc, input int rst_cyc);
      int exp_start [NV];
      int cap_c [NV];
      int n_exp = 0, exp_end = 0, e = 0, t = 2, c = 0, nload = 0, nstart = 0, vk = -1, ls = -1, lk = 0;
      bit exp_err = 1'b0, fin = 1'b0;
      logic [15:0] exp_map = '0, part_map = '0;
      for (int k = 0; k < NV; k++) begin exp_start[k] = 1 << 30; cap_c[k] = 1 << 30; end
      for (int k = 0; k < NV; k++) begin
         exp_start[k] = t; n_exp++;
         if (stale) e = 2;
         else if (dly[k] == 0) e = TO + 1;
         else e = (dly[k] < 2) ? 2 : dly[k];
         if (e > TO) begin exp_err = 1'b1; exp_end = t + TO + 1; break; end
         cap_c[k] = t + e + 1;
         exp_map |= res[k];
         if (k == NV - 1) exp_end = t + e + 2; else t = t + e + 3;
      end
      for (int k = 0; k < NV; k++) if (cap_c[k] < abort_cyc) part_map |= res[k];

      bist_start = 1'b1;
      stw.STW_complete_out = stale;
      stw.STW_result_mat = 16'($urandom);
      while (!fin) begin
         @(negedge clk); c++;
         bist_start = 1'b0; bist_abort = 1'b0; vec_wr_en = 1'b0; rst = 1'b0;
         if (stw.STW_test_load_en) begin
            nload++;
            if (nload > n_exp) check({tag, "_extra_load"}, nload, n_exp);
            else begin
               lk = nload - 1;
               check({tag, "_load_cyc"}, c, exp_start[lk] - 1);
               check({tag, "_load_idx"}, vec_idx, lk);
               check({tag, "_op1"}, stw.STW_mult_op1, slot_m[lk][15:0]);
               check({tag, "_op2"}, stw.STW_mult_op2, slot_m[lk][31:16]);
               check({tag, "_add"}, stw.STW_add_op, slot_m[lk][47:32]);
               check({tag, "_expected"}, stw.STW_expected, stw_exp(slot_m[lk]));
            end
         end
         if (stw.STW_start) begin
            nstart++; ls = c; vk = nstart - 1;
            if (nstart > n_exp) check({tag, "_extra_start"}, nstart, n_exp);
            else check({tag, "_start_cyc"}, c, exp_start[vk]);
            if (vk >= NV) vk = NV - 1;
            if (!stale) stw.STW_complete_out = 1'b0;
         end
         if (abort_cyc > 0 && c == abort_cyc + 1) begin
            check({tag, "_busy"}, busy, 0);
            check({tag, "_ops"}, {stw.STW_mult_op1, stw.STW_mult_op2, stw.STW_add_op}, 0);
            check({tag, "_strb"}, {stw.STW_test_load_en, stw.STW_start}, 0);
            check({tag, "_flags"}, {done, timeout_err}, 0);
            check({tag, "_map"}, fault_map, part_map);
            fin = 1'b1;
         end else if (rst_cyc > 0 && c == rst_cyc + 1) begin
            for (int k = 0; k < NV; k++) slot_m[k] = '0;
            check_zero({tag, "_rst"});
            fin = 1'b1;
         end else if (done || timeout_err) begin
            check({tag, "_end_cyc"}, c, exp_end);
            check({tag, "_done"}, done, !exp_err);
            check({tag, "_tmo"}, timeout_err, exp_err);
            check({tag, "_busy"}, busy, 0);
            check({tag, "_map"}, fault_map, exp_map);
            check({tag, "_any"}, any_fault, exp_map != 0);
            check({tag, "_n_start"}, nstart, n_exp);
            check({tag, "_n_load"}, nload, n_exp);
            fin = 1'b1;
         end else if (c > 200) begin
            check({tag, "_no_end"}, c, exp_end);
            fin = 1'b1;
         end
         if (!fin) begin
            if (c == abort_cyc) bist_abort = 1'b1;
            if (c == rst_cyc) rst = 1'b1;
            if (c == intr_cyc) begin
               bist_start = 1'b1; vec_wr_en = 1'b1; vec_wr_addr = 1'b0; vec_wr_data = ~slot_m[0];
            end
            if (!stale) stw.STW_complete_out = (vk >= 0) && (dly[vk] != 0) && (c >= ls + dly[vk]);
            stw.STW_result_mat = stw.STW_complete_out ? res[(vk < 0) ? 0 : vk] : 16'($urandom);
         end
      end
   endtask

   initial begin
      int starts;
      rst = 1'b1; bist_start = 1'b0; bist_abort = 1'b0; vec_wr_en = 1'b0;
      vec_wr_addr = '0; vec_wr_data = '0;
      stw.STW_complete_out = 1'b0; stw.STW_result_mat = '0;
      for (int k = 0; k < NV; k++) slot_m[k] = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      write_slot(0, {16'h0003, 16'h0005, 16'h0007});
      write_slot(1, {16'hFFFF, 16'h0002, 16'h8000});
      dly[0] = 2; dly[1] = 2; res[0] = 16'h0000; res[1] = 16'h0000;
      run_bist("basic", 1'b0, 0, 0, 0);

      res[0] = 16'h0010; res[1] = 16'h0001;
      run_bist("faults", 1'b0, 0, 0, 0);

      res[0] = 16'h0200; res[1] = 16'h0000;
      run_bist("stale", 1'b1, 0, 0, 0);

      dly[0] = 0; dly[1] = 0;
      run_bist("tmo_v0", 1'b0, 0, 0, 0);
      starts = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (stw.STW_start) starts++;
      end
      check("tmo_no_restart", starts, 0);
      check("tmo_hold", {timeout_err, done, busy}, 3'b100);

      dly[0] = 3; dly[1] = 0; res[0] = 16'h0100; res[1] = 16'hFFFF;
      run_bist("tmo_v1", 1'b0, 0, 0, 0);

      dly[0] = 2; dly[1] = 6; res[0] = 16'h0800; res[1] = 16'h0002;
      run_bist("abort", 1'b0, 9, 0, 0);

      dly[0] = 4; dly[1] = 3; res[0] = 16'h0000; res[1] = 16'h4000;
      run_bist("intr", 1'b0, 0, 4, 0);
      run_bist("rerun", 1'b0, 0, 0, 0);

      dly[0] = 2; dly[1] = 2;
      run_bist("rst_start", 1'b0, 0, 0, 2);
      run_bist("after_rst", 1'b0, 0, 0, 0);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 1) write_slot(0, {16'($urandom), 32'($urandom)});
         if ($urandom_range(0, 1) == 1) write_slot(1, {16'($urandom), 32'($urandom)});
         for (int k = 0; k < NV; k++) begin
            dly[k] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
            res[k] = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
         end
         run_bist("rand", $urandom_range(0, 3) == 0, 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stw_bist_sequencer.md
Name: stw_bist_sequencer

Overview:
- Controller that runs the self-test-word (STW) BIST over the weight-stationary MAC array. It sequences a programmable list of test vectors into the array's broadcast STW port and waits for the array's AND-reduced completion.
- It accumulates the per-PE pass/fail matrix into a sticky fault map and reports done or timeout.
- It sits between the test/repair control logic and the array; the fault map feeds the repair (recompute-unit) allocation.

Parameters:
- ROWS, 4, array rows
- COLS, 4, array columns
- WORD_SIZE, 16, operand width
- NUM_VECTORS, 4, test-vector slots (>=1)
- TIMEOUT_CYCLES, 64, max WAIT cycles per vector before abort (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous active-high
- bist_start  in  1  start pulse; honoured only in IDLE, DONE or ERROR
- bist_abort  in  1  return to IDLE from any busy state
- vec_wr_en  in  1  write a vector slot; ignored while busy
- vec_wr_addr  in  clog2(NUM_VECTORS) (min 1)  slot index
- vec_wr_data  in  3*WORD_SIZE  {add_op, op2, op1}, op1 in LSBs
- STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected  out  WORD_SIZE each  to array
- STW_test_load_en  out  1  to array
- STW_start  out  1  to array
- STW_complete_out  in  1  from array (AND of all PE completes)
- STW_result_mat  in  ROWS*COLS  from array; bit r*COLS+c = 1 means PE(r,c) mismatched
- busy  out  1  sequence in progress
- done  out  1  level; sequence finished without timeout
- timeout_err  out  1  level; sequence ended on timeout
- vec_idx  out  clog2(NUM_VECTORS)  vector currently applied
- fault_map  out  ROWS*COLS  sticky OR of STW_result_mat over the vectors run
- any_fault  out  1  |fault_map

Behaviour:
- Reset: state=IDLE. All outputs are 0 and all vector slots are 0.
- Vector RAM: registered write on vec_wr_en when not busy. An out-of-range address is ignored.
- Expected value: STW_expected = (op1*op2 + add_op) mod 2^WORD_SIZE, unsigned, computed from the current slot.
- Operand hold: operand outputs are registered. They load in LOAD and are held stable until the next LOAD or IDLE; in IDLE they are 0.
- States:
  - IDLE: on bist_start, clear fault_map, done and timeout_err; set vec_idx=0; go to LOAD.
  - LOAD: operands from slot vec_idx; STW_test_load_en=1 for exactly this cycle; go to START.
  - START: STW_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: the first WAIT cycle ignores STW_complete_out (stale-level guard). After that, complete=1 goes to CAPTURE. The counter increments each WAIT cycle; if it reaches TIMEOUT_CYCLES without complete, go to ERROR.
  - CAPTURE: fault_map |= STW_result_mat. If vec_idx==NUM_VECTORS-1, go to DONE; else vec_idx+1 and go to LOAD.
  - DONE: done=1; stay until bist_start (restart as from IDLE).
  - ERROR: timeout_err=1. fault_map keeps the results of the vectors captured so far. Stay until bist_start.
- busy=1 in LOAD, START, WAIT and CAPTURE.
- Latency: start sampled in cycle 0 → LOAD in cycle 1 → START in cycle 2 → WAIT from cycle 3. If complete is high in cycle 4, CAPTURE is in cycle 5. Per vector minimum is 5 cycles, so NUM_VECTORS=1 reaches done in cycle 6.
- bist_abort while busy: next state IDLE. Operands, load_en and start are 0. done=timeout_err=0; fault_map is retained.
- Simultaneous events:
  - abort has priority over start and complete.
  - bist_start while busy is ignored.
  - vec_wr_en while busy is dropped.
- rst mid-sequence: same as reset; the in-flight array test is simply abandoned.

Test Plan:
- Write slot0={add=3, op2=5, op1=7}, slot1={add=0xFFFF, op2=2, op1=0x8000} (NUM_VECTORS=2), pulse start; array model completes 2 cycles after STW_start with result_mat=0 → STW_expected 0x0026 then 0xFFFF; exactly one load_en and one start pulse per vector; done=1, fault_map=0, any_fault=0.
- Same run, model returns result_mat=0x0010 on vector 0 and 0x0001 on vector 1 → fault_map=0x0011, any_fault=1, done=1.
- Model never asserts complete (TIMEOUT_CYCLES=8) → ERROR after 8 WAIT cycles; timeout_err=1, done=0, busy=0, no further STW_start pulses.
- Complete held high continuously from before start → first WAIT cycle ignored; CAPTURE occurs in cycle 5, not cycle 4.
- bist_abort in WAIT of vector 1 → IDLE next cycle; busy=0, operands=0, vector-0 fault bits are retained in fault_map.
- vec_wr_en during WAIT → slot unchanged (verified by a rerun); bist_start during WAIT ignored; rst asserted in START → all outputs 0 on the next cycle.
